lfsr_gen: RTL
=============

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 The parameter WIDTH SHALL default to 8, legal range 3..32, and set the register width.
REQ-002 The parameter TAPS SHALL be [WIDTH-1:0], default 8'hB8, and act as the feedback mask (bit i set = stage i taps).
REQ-003 The parameter SEED SHALL be [WIDTH-1:0], default 1, and be the reset and lockup-recovery value; it SHALL be nonzero.
REQ-004 The parameter MODE SHALL default to 0 and select the topology: 0 = Fibonacci, 1 = Galois.
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock, rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-007 Port en SHALL be an input, 1 bit wide: advance the state one step per cycle.
REQ-008 Port load SHALL be an input, 1 bit wide: replace the state with seed_in.
REQ-009 Port seed_in SHALL be an input, WIDTH bits wide: the value to load.
REQ-010 Port q SHALL be an output, WIDTH bits wide: the current state, driven from a register.
REQ-011 Port bit_out SHALL be an output, 1 bit wide: equal to q[WIDTH-1] in Fibonacci mode and q[0] in Galois mode.
REQ-012 Port wrap SHALL be an output, 1 bit wide: a one-cycle pulse when the state returns to its start value.
REQ-013 Port period SHALL be an output, WIDTH bits wide: the step count of the last completed cycle.
REQ-014 Port lockup SHALL be an output, 1 bit wide: a one-cycle pulse when all-zero recovery occurs.

Function
REQ-015 In Fibonacci mode, the step SHALL be q <= {q[WIDTH-2:0], ^(q & TAPS)}.
REQ-016 In Galois mode, the step SHALL be q <= (q >> 1) ^ (q[0] ? TAPS : 0).
REQ-017 Priority SHALL be load > lockup recovery > en > hold.
REQ-018 When load=1, the next q SHALL be seed_in, start SHALL be set to seed_in, and count SHALL be cleared to 0; wrap and lockup SHALL be 0 that cycle.
REQ-019 If load=1 with seed_in=0, the state SHALL take 0 and rely on REQ-020 for recovery.
REQ-020 If en=1, load=0 and q=0, the next q SHALL be SEED, start SHALL be set to SEED, count SHALL be cleared, and lockup SHALL pulse on the following cycle.
REQ-021 When en=0 and load=0, q, start, count and period SHALL hold.
REQ-022 On each normal step, count SHALL increment; if the next q equals start, wrap SHALL pulse on the following cycle, period SHALL take count+1 (modulo 2^WIDTH), and count SHALL clear.
REQ-023 The count SHALL wrap modulo 2^WIDTH without saturating, so a maximal sequence reports period = 2^WIDTH-1.
REQ-024 The wrap and lockup outputs SHALL be registered pulses, asserted exactly one cycle per event and never simultaneously.
REQ-025 Latency SHALL be one cycle from en or load to q.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously set q=SEED, start=SEED, count=0, period=0, wrap=0 and lockup=0.
REQ-027 Reset deassertion mid-sequence SHALL restart the sequence from SEED, with the first step on the first cycle after release with en=1.

Structure
REQ-028 A package lfsr_pkg SHALL hold the MODE encoding constants (LFSR_FIB, LFSR_GAL) and the default tap masks for widths 3..32.
REQ-029 The next-state XOR logic SHALL be a combinational sub-module lfsr_next (WIDTH, TAPS, MODE; in q, out q_nxt) instantiated once.
REQ-030 The period/wrap tracking and lockup handling SHALL reside in lfsr_gen.

Verification
REQ-031 With WIDTH=4, TAPS=4'b1100, MODE=0, SEED=1 and en held high, q SHALL step 0001, 0010, 0100, 1001, 0011.
REQ-032 With the same parameters, wrap SHALL pulse after 15 steps with period=15, then again 15 steps later.
REQ-033 With MODE=1 and the same parameters, q SHALL visit 15 distinct nonzero states before wrap, with period=15.
REQ-034 With load=1 and seed_in=0 followed by en=1, q SHALL become 0, then 0001, with lockup pulsing one cycle.
REQ-035 With load=1 and seed_in=4'b1001 asserted together with en, q SHALL equal 1001 (load wins), and wrap SHALL next pulse when q returns to 1001.
REQ-036 With rst_n asserted low asynchronously mid-sequence, between clock edges, q SHALL become SEED immediately, and period and count SHALL read 0.

Source files
------------

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - LFSR topology encodings and default maximal-length tap masks.
package lfsr_pkg;

    localparam int LFSR_FIB = 0;
    localparam int LFSR_GAL = 1;

    // Mask bit i set means stage i feeds the XOR; each entry gives a maximal sequence.
    function automatic logic [31:0] lfsr_default_taps(input int width);
        logic [31:0] taps;
        case (width)
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_00B8;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - Combinational one-step LFSR advance, Fibonacci or Galois.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
    parameter int               MODE  = LFSR_FIB
) (
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_nxt
);

    generate
        if (MODE == LFSR_GAL) begin : g_galois
            assign q_nxt = (q >> 1) ^ (q[0] ? TAPS : '0);
        end else begin : g_fibonacci
            assign q_nxt = {q[WIDTH-2:0], ^(q & TAPS)};
        end
    endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - LFSR generator with load, all-zero lockup recovery and period tracking.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               MODE  = LFSR_FIB
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] count_inc;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .q     (q_q),
        .q_nxt (q_nxt)
    );

    // Count wraps modulo 2^WIDTH, so a maximal run reports 2^WIDTH-1.
    assign count_inc = count_q + WIDTH'(1);

    always_comb begin
        q_d      = q_q;
        start_d  = start_q;
        count_d  = count_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            q_d     = seed_in;
            start_d = seed_in;
            count_d = '0;
        end else if (en && (q_q == '0)) begin
            q_d      = SEED;
            start_d  = SEED;
            count_d  = '0;
            lockup_d = 1'b1;
        end else if (en) begin
            q_d = q_nxt;
            if (q_nxt == start_q) begin
                wrap_d   = 1'b1;
                period_d = count_inc;
                count_d  = '0;
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= SEED;
            start_q  <= SEED;
            count_q  <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            start_q  <= start_d;
            count_q  <= count_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign q       = q_q;
    assign bit_out = (MODE == LFSR_GAL) ? q_q[0] : q_q[WIDTH-1];
    assign wrap    = wrap_q;
    assign period  = period_q;
    assign lockup  = lockup_q;

endmodule
